// File: rtl/instr_encoder.sv
// instr_encoder
// Packs decoded instruction descriptors into 32-bit RV32I/RVX10 instruction
// words and streams them to consecutive instruction-memory word addresses.
// It is the inverse of the ID-stage opcode decoder and is used to fill the
// instruction memory before the core runs.
//
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   clear           synchronous restart of the fill sequence
//   in_valid/ready  descriptor handshake
//   in_cls..in_imm  descriptor fields (class, registers, functs, immediate)
//   wr_en/ready     registered write port to instruction memory
//   wr_addr/data    word address and encoded instruction
//   count, full     descriptors accepted and memory-full flag
//   err, err_addr   sticky immediate-range error and first offending address
module instr_encoder #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cls,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [2:0] CLS_LOAD    = 3'd0;
  localparam logic [2:0] CLS_STORE   = 3'd1;
  localparam logic [2:0] CLS_RTYPE   = 3'd2;
  localparam logic [2:0] CLS_ITYPE   = 3'd3;
  localparam logic [2:0] CLS_BRANCH  = 3'd4;
  localparam logic [2:0] CLS_JAL     = 3'd5;
  localparam logic [2:0] CLS_JALR    = 3'd6;
  localparam logic [2:0] CLS_CUSTOM0 = 3'd7;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] OP_ITYPE   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic        accept;
  logic        is_shift;
  logic        fits12;
  logic        fits_shamt;
  logic        fits_branch;
  logic        fits_jal;
  logic        imm_bad;
  logic [31:0] enc_word;

  // The output register may take a new word when it is empty or its current
  // word is leaving this cycle; clear and reset both block acceptance.
  assign full     = (count == DEPTH_CNT);
  assign in_ready = reset && !full && (!wr_en || wr_ready) && !clear;
  assign accept   = in_valid && in_ready;

  // A value fits an N-bit signed field when all bits above N-1 equal the
  // sign bit, i.e. they are all ones or all zeros.
  assign is_shift    = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign fits12      = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fits_shamt  = !(|in_imm[31:5]);
  assign fits_branch = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
  assign fits_jal    = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];

  always_comb begin
    enc_word = '0;
    imm_bad  = 1'b0;
    case (in_cls)
      CLS_LOAD: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        imm_bad  = !fits12;
      end
      CLS_STORE: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        imm_bad  = !fits12;
      end
      CLS_RTYPE: begin
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_RTYPE};
      end
      CLS_ITYPE: begin
        // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
        if (is_shift) begin
          enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_ITYPE};
          imm_bad  = !fits_shamt;
        end else begin
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ITYPE};
          imm_bad  = !fits12;
        end
      end
      CLS_BRANCH: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], OP_BRANCH};
        imm_bad  = !fits_branch;
      end
      CLS_JAL: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        imm_bad  = !fits_jal;
      end
      CLS_JALR: begin
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
        imm_bad  = !fits12;
      end
      CLS_CUSTOM0: begin
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_CUSTOM0};
      end
      default: begin
        enc_word = '0;
        imm_bad  = 1'b0;
      end
    endcase
  end

  // Output register and fill bookkeeping. An accepted word always replaces
  // the register contents (the old word, if any, is leaving this cycle);
  // otherwise the register empties once memory takes the word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      count    <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else if (clear) begin
      wr_en    <= 1'b0;
      count    <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else if (accept) begin
      wr_en   <= 1'b1;
      wr_addr <= count[ADDR_W-1:0];
      wr_data <= enc_word;
      count   <= count + CNT_ONE;
      if (imm_bad) begin
        err <= 1'b1;
        if (!err) begin
          err_addr <= count[ADDR_W-1:0];
        end
      end
    end else if (wr_ready) begin
      wr_en <= 1'b0;
    end
  end

endmodule
